rf_ctx_ctrl: RTL and testbench
==============================

RF_CTX_CTRL -- requirements
Module: rf_ctx_ctrl

Interface
REQ-001 SHALL have parameters: PC_WIDTH, default 6, program-counter and stack-pointer width; DEPTH, default 8, maximum stored frames (1..2^PC_WIDTH-1).
REQ-002 SHALL have ports: clk, input, 1, sole clock, all logic on rising edge.
REQ-003 SHALL have ports: rst_n, input, 1, reset, synchronous and active-low.
REQ-004 SHALL have ports: call_req, input, 1, save context and enter subroutine; call_pc, input, PC_WIDTH, return address to store.
REQ-005 SHALL have ports: ret_req, input, 1, restore most recent context; err_clr, input, 1, clear sticky errors.
REQ-006 SHALL have ports: busy, output, 1, sequence in progress; done, output, 1, one-cycle completion pulse.
REQ-007 SHALL have ports: ret_pc, output, PC_WIDTH, restored return address; ret_pc_valid, output, 1, one-cycle pulse with ret_pc.
REQ-008 SHALL have ports: rf_stack_push, output, 1; rf_stack_pop, output, 1; rf_stack_pointer, output, PC_WIDTH; these drive the register-file stack interface.
REQ-009 SHALL have ports: full, output, 1; empty, output, 1; err_ovf, output, 1; err_unf, output, 1.

Function
REQ-010 SHALL keep sp, the frame count; 0 = empty, and sp addresses the last pushed frame; rf_stack_pointer = sp.
REQ-011 SHALL use FSM states IDLE, C_INC, C_PUSH, R_WAIT, R_POP, R_DEC; busy=1 in every state except IDLE.
REQ-012 SHALL sample call_req/ret_req only in IDLE; requests in other states are ignored, not queued.
REQ-013 SHALL give call priority when call_req and ret_req are both 1 in IDLE; ret_req is dropped.
REQ-014 Call with sp<DEPTH: IDLE->C_INC (sp<=sp+1, call_pc latched into frame sp+1)->C_PUSH (rf_stack_push=1 for exactly one cycle, done=1)->IDLE.
REQ-015 Return with sp>0: IDLE->R_WAIT (pointer stable, one cycle of stack read latency)->R_POP (rf_stack_pop=1 for one cycle, ret_pc driven, ret_pc_valid=1)->R_DEC (sp<=sp-1, done=1)->IDLE.
REQ-016 Call with sp==DEPTH: SHALL stay in IDLE, leave sp unchanged, set err_ovf, and not pulse done or push.
REQ-017 Return with sp==0: SHALL stay in IDLE, set err_unf, and not pulse done, pop or ret_pc_valid.
REQ-018 SHALL keep err_ovf/err_unf sticky until err_clr=1; setting and clearing in the same cycle leaves the flag set.
REQ-019 SHALL keep rf_stack_push and rf_stack_pop mutually exclusive and never assert either in IDLE.
REQ-020 SHALL drive full=(sp==DEPTH) and empty=(sp==0) combinationally from registered sp.
REQ-021 SHALL hold rf_stack_pointer constant from R_WAIT through R_POP.

Reset
REQ-022 When rst_n=0 at a clock edge, SHALL set: state=IDLE, sp=0, busy=0, done=0, rf_stack_push=0, rf_stack_pop=0, ret_pc=0, ret_pc_valid=0, err_ovf=0, err_unf=0; full=0, empty=1.
REQ-023 Reset mid-sequence SHALL abort at that edge with no further strobes; stored frame contents need not be cleared.

Configuration
REQ-024 With RF_CTX_RET_PC_EN defined, SHALL store call_pc per frame (DEPTH entries) and return it per REQ-015.
REQ-025 Without RF_CTX_RET_PC_EN, SHALL omit return-address storage, ignore call_pc, and tie ret_pc to 0; ret_pc_valid still pulses per REQ-015.

Structure
REQ-026 SHALL define the FSM state enum and a DEPTH default constant in shared package rf_ctx_pkg.
REQ-027 SHALL place return-address storage in sub-module rf_ret_lifo (write at index, async read at index), instantiated only under RF_CTX_RET_PC_EN.

Verification
REQ-028 Reset, then call_req=1, call_pc=6'h15 -> rf_stack_push high on 2nd cycle, rf_stack_pointer=1, done with it, then busy=0.
REQ-029 Two calls (pc 6'h05, 6'h0A), then two returns -> ret_pc=6'h0A then 6'h05; pop pointers 2 then 1; empty=1 at end.
REQ-030 Eight calls with DEPTH=8 -> full=1; ninth call -> err_ovf=1, no push, sp stays 8; err_clr -> err_ovf=0.
REQ-031 ret_req from empty -> err_unf=1, no pop, done=0; call_req and ret_req together in IDLE -> call executed only.
REQ-032 rst_n=0 during R_WAIT after one call -> next cycle sp=0, no pop, busy=0; rerun REQ-028 and REQ-029 without RF_CTX_RET_PC_EN -> ret_pc=0 throughout.

Source files
------------

// File: rtl/rf_ctx_pkg.sv
// Shared types and constants for the call/return context controller.
// The RF_CTX_RET_PC_EN macro selects whether return addresses are stored.
package rf_ctx_pkg;

  localparam int RF_CTX_PC_WIDTH_DEFAULT = 6;
  localparam int RF_CTX_DEPTH_DEFAULT    = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    C_INC  = 3'd1,
    C_PUSH = 3'd2,
    R_WAIT = 3'd3,
    R_POP  = 3'd4,
    R_DEC  = 3'd5
  } ctx_state_e;

endpackage

// File: rtl/rf_ctx_ctrl_ret_lifo.sv
// Return-address storage: one entry per frame, synchronous write, async read.
// Built only when RF_CTX_RET_PC_EN is defined.
module rf_ret_lifo #(
  parameter int PC_WIDTH = 6,
  parameter int DEPTH    = 8
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [PC_WIDTH-1:0] wr_idx,
  input  logic [PC_WIDTH-1:0] wr_data,
  input  logic [PC_WIDTH-1:0] rd_idx,
  output logic [PC_WIDTH-1:0] rd_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PC_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]       wr_a;
  logic [AW-1:0]       rd_a;

  assign wr_a    = AW'(wr_idx);
  assign rd_a    = AW'(rd_idx);
  assign rd_data = mem_q[rd_a];

  // Frame contents survive reset; only the controller pointer is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_a] <= wr_data;
    end
  end

endmodule

// File: rtl/rf_ctx_ctrl.sv
// Subroutine context controller: sequences register-file stack push/pop for
// call and return. Define RF_CTX_RET_PC_EN to store and return call_pc per frame.
module rf_ctx_ctrl
  import rf_ctx_pkg::*;
#(
  parameter int PC_WIDTH = RF_CTX_PC_WIDTH_DEFAULT,
  parameter int DEPTH    = RF_CTX_DEPTH_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                call_req,
  input  logic [PC_WIDTH-1:0] call_pc,
  input  logic                ret_req,
  input  logic                err_clr,
  output logic                busy,
  output logic                done,
  output logic [PC_WIDTH-1:0] ret_pc,
  output logic                ret_pc_valid,
  output logic                rf_stack_push,
  output logic                rf_stack_pop,
  output logic [PC_WIDTH-1:0] rf_stack_pointer,
  output logic                full,
  output logic                empty,
  output logic                err_ovf,
  output logic                err_unf
);

  localparam logic [PC_WIDTH-1:0] DEPTH_W = PC_WIDTH'(DEPTH);
  localparam logic [PC_WIDTH-1:0] ONE_W   = PC_WIDTH'(1'b1);
  localparam logic [PC_WIDTH-1:0] ZERO_W  = {PC_WIDTH{1'b0}};

  ctx_state_e          state_q, state_d;
  logic [PC_WIDTH-1:0] sp_q, sp_d;
  logic [PC_WIDTH-1:0] ret_pc_q, ret_pc_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                push_q, push_d;
  logic                pop_q, pop_d;
  logic                valid_q, valid_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic [PC_WIDTH-1:0] rd_pc;

`ifdef RF_CTX_RET_PC_EN
  logic [PC_WIDTH-1:0] pc_q, pc_d;

  // Hold the return address from the accepted request until the frame is written.
  always_comb begin
    pc_d = pc_q;
    if ((state_q == IDLE) && call_req && (sp_q != DEPTH_W)) begin
      pc_d = call_pc;
    end else begin
      pc_d = pc_q;
    end
  end

  // Return-address holding register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= ZERO_W;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Frame n lives at index n-1: write at sp before increment, read at sp-1.
  rf_ret_lifo #(
    .PC_WIDTH (PC_WIDTH),
    .DEPTH    (DEPTH)
  ) u_ret_lifo (
    .clk     (clk),
    .wr_en   (state_q == C_INC),
    .wr_idx  (sp_q),
    .wr_data (pc_q),
    .rd_idx  (sp_q - ONE_W),
    .rd_data (rd_pc)
  );
`else
  logic unused_call_pc;
  assign unused_call_pc = ^call_pc;
  assign rd_pc          = ZERO_W;
`endif

  // Next-state and next-output logic; strobes are computed one state early
  // so that the registered outputs line up with C_PUSH, R_POP and R_DEC.
  always_comb begin
    state_d  = state_q;
    sp_d     = sp_q;
    ret_pc_d = ret_pc_q;
    done_d   = 1'b0;
    push_d   = 1'b0;
    pop_d    = 1'b0;
    valid_d  = 1'b0;
    ovf_d    = err_clr ? 1'b0 : ovf_q;
    unf_d    = err_clr ? 1'b0 : unf_q;
    case (state_q)
      IDLE: begin
        if (call_req) begin
          if (sp_q != DEPTH_W) begin
            state_d = C_INC;
          end else begin
            ovf_d = 1'b1;
          end
        end else if (ret_req) begin
          if (sp_q != ZERO_W) begin
            state_d = R_WAIT;
          end else begin
            unf_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      C_INC: begin
        sp_d    = sp_q + ONE_W;
        push_d  = 1'b1;
        done_d  = 1'b1;
        state_d = C_PUSH;
      end
      C_PUSH: begin
        state_d = IDLE;
      end
      R_WAIT: begin
        pop_d    = 1'b1;
        valid_d  = 1'b1;
        ret_pc_d = rd_pc;
        state_d  = R_POP;
      end
      R_POP: begin
        done_d  = 1'b1;
        state_d = R_DEC;
      end
      R_DEC: begin
        sp_d    = sp_q - ONE_W;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sp_q     <= ZERO_W;
      ret_pc_q <= ZERO_W;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      push_q   <= 1'b0;
      pop_q    <= 1'b0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sp_q     <= sp_d;
      ret_pc_q <= ret_pc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      push_q   <= push_d;
      pop_q    <= pop_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign ret_pc           = ret_pc_q;
  assign ret_pc_valid     = valid_q;
  assign rf_stack_push    = push_q;
  assign rf_stack_pop     = pop_q;
  assign rf_stack_pointer = sp_q;
  assign full             = (sp_q == DEPTH_W);
  assign empty            = (sp_q == ZERO_W);
  assign err_ovf          = ovf_q;
  assign err_unf          = unf_q;

endmodule

// File: tb/tb_rf_ctx_ctrl.sv
// Directed self-checking bench for rf_ctx_ctrl (default parameters).
// Expected ret_pc follows RF_CTX_RET_PC_EN the same way as the design build.
module tb_rf_ctx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, call_req, ret_req, err_clr;
  logic [5:0] call_pc;
  logic       busy, done, ret_pc_valid, rf_stack_push, rf_stack_pop;
  logic       full, empty, err_ovf, err_unf;
  logic [5:0] ret_pc, rf_stack_pointer;

  int checks = 0;
  int passes = 0;

`ifdef RF_CTX_RET_PC_EN
  localparam bit RET_EN = 1'b1;
`else
  localparam bit RET_EN = 1'b0;
`endif

  rf_ctx_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .call_req         (call_req),
    .call_pc          (call_pc),
    .ret_req          (ret_req),
    .err_clr          (err_clr),
    .busy             (busy),
    .done             (done),
    .ret_pc           (ret_pc),
    .ret_pc_valid     (ret_pc_valid),
    .rf_stack_push    (rf_stack_push),
    .rf_stack_pop     (rf_stack_pop),
    .rf_stack_pointer (rf_stack_pointer),
    .full             (full),
    .empty            (empty),
    .err_ovf          (err_ovf),
    .err_unf          (err_unf)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0; call_req = 1'b0; ret_req = 1'b0; err_clr = 1'b0; call_pc = 6'h00;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  // One call; checks a single push with the expected pointer and a done alongside it.
  task automatic do_call(input logic [5:0] pc, input logic [5:0] exp_sp);
    int n_push = 0, n_done = 0, n_pop = 0;
    logic [5:0] ptr_at_push = 6'h3f;
    call_req = 1'b1; call_pc = pc;
    tick();
    call_req = 1'b0; call_pc = 6'h3f;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rf_stack_push) begin n_push++; ptr_at_push = rf_stack_pointer; end
      if (done) n_done++;
      if (rf_stack_pop) n_pop++;
      if (done !== rf_stack_push) n_done = 99;
      if (!busy) break;
    end
    checks++; if (busy !== 1'b0) $display("FAIL call_timeout: busy=%0b exp 0", busy); else passes++;
    checks++; if (n_push != 1 || n_pop != 0) $display("FAIL call_push_cnt: push=%0d pop=%0d exp 1/0", n_push, n_pop); else passes++;
    checks++; if (n_done != 1) $display("FAIL call_done: count=%0d exp 1 with push", n_done); else passes++;
    checks++; if (ptr_at_push !== exp_sp) $display("FAIL call_ptr: got %0d exp %0d", ptr_at_push, exp_sp); else passes++;
  endtask

  // One return; checks pointer stability, a single pop/valid with ret_pc, then done.
  task automatic do_ret(input logic [5:0] pc, input logic [5:0] exp_ptr);
    int n_pop = 0, n_valid = 0, n_done = 0, n_push = 0;
    logic [5:0] ptr_wait, ptr_pop = 6'h3f, got_pc = 6'h3f;
    logic [5:0] exp_pc;
    exp_pc = RET_EN ? pc : 6'h00;
    ret_req = 1'b1;
    tick();
    ret_req = 1'b0;
    ptr_wait = rf_stack_pointer;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rf_stack_pop) begin n_pop++; ptr_pop = rf_stack_pointer; end
      if (ret_pc_valid) begin n_valid++; got_pc = ret_pc; end
      if (done) n_done++;
      if (rf_stack_push) n_push++;
      if (!busy) break;
    end
    checks++; if (busy !== 1'b0) $display("FAIL ret_timeout: busy=%0b exp 0", busy); else passes++;
    checks++; if (n_pop != 1 || n_valid != 1 || n_push != 0) $display("FAIL ret_pulses: pop=%0d valid=%0d push=%0d exp 1/1/0", n_pop, n_valid, n_push); else passes++;
    checks++; if (n_done != 1) $display("FAIL ret_done: count=%0d exp 1", n_done); else passes++;
    checks++; if (ptr_pop !== exp_ptr || ptr_wait !== exp_ptr) $display("FAIL ret_ptr: wait=%0d pop=%0d exp %0d", ptr_wait, ptr_pop, exp_ptr); else passes++;
    checks++; if (got_pc !== exp_pc) $display("FAIL ret_pc: got %h exp %h", got_pc, exp_pc); else passes++;
    checks++; if (rf_stack_pointer !== exp_ptr - 6'd1) $display("FAIL ret_sp_after: got %0d exp %0d", rf_stack_pointer, exp_ptr - 6'd1); else passes++;
  endtask

  task automatic test_reset;
    apply_reset();
    checks++; if ({busy, done, rf_stack_push, rf_stack_pop, ret_pc_valid} !== 5'b00000) $display("FAIL reset_strobes: got %b exp 00000", {busy, done, rf_stack_push, rf_stack_pop, ret_pc_valid}); else passes++;
    checks++; if ({err_ovf, err_unf, full, empty} !== 4'b0001) $display("FAIL reset_flags: got %b exp 0001", {err_ovf, err_unf, full, empty}); else passes++;
    checks++; if (ret_pc !== 6'h00 || rf_stack_pointer !== 6'h00) $display("FAIL reset_regs: ret_pc=%h sp=%0d exp 0/0", ret_pc, rf_stack_pointer); else passes++;
  endtask

  task automatic test_single_call;
    apply_reset();
    call_req = 1'b1; call_pc = 6'h15;
    tick();
    call_req = 1'b0;
    checks++; if (busy !== 1'b1 || rf_stack_push !== 1'b0) $display("FAIL c1_cycle1: busy=%0b push=%0b exp 1/0", busy, rf_stack_push); else passes++;
    tick();
    checks++; if (rf_stack_push !== 1'b1 || done !== 1'b1) $display("FAIL c1_cycle2: push=%0b done=%0b exp 1/1", rf_stack_push, done); else passes++;
    checks++; if (rf_stack_pointer !== 6'd1) $display("FAIL c1_ptr: got %0d exp 1", rf_stack_pointer); else passes++;
    tick();
    checks++; if ({busy, rf_stack_push, done} !== 3'b000) $display("FAIL c1_idle: got %b exp 000", {busy, rf_stack_push, done}); else passes++;
    checks++; if (empty !== 1'b0 || ret_pc !== 6'h00) $display("FAIL c1_state: empty=%0b ret_pc=%h exp 0/00", empty, ret_pc); else passes++;
  endtask

  task automatic test_two_calls_rets;
    apply_reset();
    do_call(6'h05, 6'd1);
    do_call(6'h0A, 6'd2);
    do_ret(6'h0A, 6'd2);
    do_ret(6'h05, 6'd1);
    checks++; if (empty !== 1'b1 || full !== 1'b0) $display("FAIL two_end: empty=%0b full=%0b exp 1/0", empty, full); else passes++;
  endtask

  task automatic test_overflow;
    apply_reset();
    for (int i = 0; i < 8; i++) do_call(6'h20 + 6'(i), 6'(i + 1));
    checks++; if (full !== 1'b1 || rf_stack_pointer !== 6'd8) $display("FAIL ovf_full: full=%0b sp=%0d exp 1/8", full, rf_stack_pointer); else passes++;
    call_req = 1'b1; call_pc = 6'h3c;
    tick();
    call_req = 1'b0;
    checks++; if ({err_ovf, busy, rf_stack_push, done} !== 4'b1000) $display("FAIL ovf_set: ovf/busy/push/done=%b exp 1000", {err_ovf, busy, rf_stack_push, done}); else passes++;
    tick();
    checks++; if (rf_stack_push !== 1'b0 || rf_stack_pointer !== 6'd8) $display("FAIL ovf_hold: push=%0b sp=%0d exp 0/8", rf_stack_push, rf_stack_pointer); else passes++;
    call_req = 1'b1; err_clr = 1'b1;
    tick();
    call_req = 1'b0;
    checks++; if (err_ovf !== 1'b1) $display("FAIL ovf_set_clr: got %0b exp 1", err_ovf); else passes++;
    tick();
    err_clr = 1'b0;
    checks++; if (err_ovf !== 1'b0) $display("FAIL ovf_clr: got %0b exp 0", err_ovf); else passes++;
    do_ret(6'h27, 6'd8);
  endtask

  task automatic test_underflow_priority;
    int n_push = 0, n_pop = 0;
    apply_reset();
    ret_req = 1'b1;
    tick();
    ret_req = 1'b0;
    checks++; if ({err_unf, busy, rf_stack_pop, done, ret_pc_valid} !== 5'b10000) $display("FAIL unf_set: got %b exp 10000", {err_unf, busy, rf_stack_pop, done, ret_pc_valid}); else passes++;
    tick();
    checks++; if ({rf_stack_pop, done, ret_pc_valid, err_unf} !== 4'b0001) $display("FAIL unf_hold: got %b exp 0001", {rf_stack_pop, done, ret_pc_valid, err_unf}); else passes++;
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    call_req = 1'b1; ret_req = 1'b1; call_pc = 6'h2A;
    tick();
    call_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      ret_req = 1'b0;
      if (rf_stack_push) n_push++;
      if (rf_stack_pop) n_pop++;
      if (!busy) break;
    end
    tick();
    if (rf_stack_pop) n_pop++;
    checks++; if (n_push != 1 || n_pop != 0) $display("FAIL prio_call: push=%0d pop=%0d exp 1/0", n_push, n_pop); else passes++;
    checks++; if (rf_stack_pointer !== 6'd1 || err_unf !== 1'b0 || busy !== 1'b0) $display("FAIL prio_state: sp=%0d unf=%0b busy=%0b exp 1/0/0", rf_stack_pointer, err_unf, busy); else passes++;
    do_ret(6'h2A, 6'd1);
  endtask

  task automatic test_reset_mid;
    apply_reset();
    do_call(6'h11, 6'd1);
    ret_req = 1'b1;
    tick();
    ret_req = 1'b0;
    checks++; if (busy !== 1'b1 || rf_stack_pop !== 1'b0) $display("FAIL mid_wait: busy=%0b pop=%0b exp 1/0", busy, rf_stack_pop); else passes++;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if ({busy, rf_stack_pop, ret_pc_valid, done, empty} !== 5'b00001 || rf_stack_pointer !== 6'd0) $display("FAIL mid_reset: busy/pop/valid/done/empty=%b sp=%0d exp 00001/0", {busy, rf_stack_pop, ret_pc_valid, done, empty}, rf_stack_pointer); else passes++;
    tick(); tick();
    checks++; if ({busy, rf_stack_pop, ret_pc_valid, done} !== 4'b0000) $display("FAIL mid_after: got %b exp 0000", {busy, rf_stack_pop, ret_pc_valid, done}); else passes++;
  endtask

  initial begin
    test_reset();
    test_single_call();
    test_two_calls_rets();
    test_overflow();
    test_underflow_priority();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
